// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   SPI mode-0 slave that turns host frames into single-cycle register-file
//   accesses. A frame is a CMD byte {r_wn, reserved[1:0], addr[4:0]} followed by
//   DATA_W data bits, MSB first. Every SPI input is oversampled in the clk domain,
//   and no logic runs on spi_sclk.
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   spi_sclk/cs_n/mosi SPI inputs (asynchronous to clk)
//   spi_miso          read data out, 0 whenever the bridge is not driving read bits
//   reg_addr/r_wn     access address / direction, held after reg_req
//   reg_wdata         write data, valid with reg_req when reg_r_wn=0
//   reg_req           one-clk access strobe
//   reg_rdata         read data, sampled 1 clk after a read reg_req
//   busy              frame in progress (state != IDLE)
//   frame_err         one-clk pulse on an aborted or rejected frame
module spi_reg_bridge #(
  parameter int ADDR_W      = 5,   // must be <= 6 to leave at least one reserved CMD bit
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_r_wn,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_req,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_RD_REQ, S_RD_CAP, S_DATA, S_WR_REQ, S_DRAIN
  } state_t;

  // Synchronisers are deliberately left out of reset. They keep tracking the pins
  // while reset is held, so a CS_n that is already low at release produces no
  // false fall edge. The bridge then waits in IDLE until CS_n has gone high and
  // falls again.
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_prev, r_cs_prev;

  always_ff @(posedge clk) begin
    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
    r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   spi_cs_n};
    r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
    r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
  end

  logic w_sclk, w_cs, w_mosi;
  logic w_rise, w_fall, w_cs_fall, w_cs_rise;
  assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    =  w_sclk & ~r_sclk_prev;
  assign w_fall    = ~w_sclk &  r_sclk_prev;
  assign w_cs_fall = ~w_cs   &  r_cs_prev;
  assign w_cs_rise =  w_cs   & ~r_cs_prev;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [6:0]        r_cmd;
  logic [DATA_W-2:0] r_rx;
  logic [DATA_W-1:0] r_tx;
  logic              r_miso, r_rwn, r_bad, r_err, w_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [7:0]        w_cmd_nxt;
  logic [DATA_W-1:0] w_rx_nxt;
  logic              w_cmd_last, w_data_last, w_rsvd_bad;
  assign w_cmd_nxt   = {r_cmd, w_mosi};
  assign w_rx_nxt    = {r_rx, w_mosi};
  assign w_cmd_last  = (r_cnt == CNT_W'(7));
  assign w_data_last = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_rsvd_bad  = |w_cmd_nxt[6:ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A CS_n rise out of any active state returns to IDLE. It is flagged as an
  // error unless the frame already finished cleanly: write strobed, read fully
  // shifted, or not rejected on its reserved bits.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE:   if (w_cs_fall) w_state_nxt = S_CMD;
      S_CMD: begin
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end else if (w_rise && w_cmd_last) begin
          if (w_rsvd_bad)        w_state_nxt = S_DRAIN;
          else if (w_cmd_nxt[7]) w_state_nxt = S_RD_REQ;
          else                   w_state_nxt = S_DATA;
        end
      end
      S_RD_REQ: begin
        w_state_nxt = w_cs_rise ? S_IDLE : S_RD_CAP;
        w_err       = w_cs_rise;
      end
      S_RD_CAP: begin
        w_state_nxt = w_cs_rise ? S_IDLE : S_DATA;
        w_err       = w_cs_rise;
      end
      S_DATA: begin
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end else if (w_rise && w_data_last) begin
          w_state_nxt = r_rwn ? S_DRAIN : S_WR_REQ;
        end
      end
      S_WR_REQ: w_state_nxt = w_cs_rise ? S_IDLE : S_DRAIN;
      S_DRAIN: begin
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
          w_err       = r_bad;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_cmd   <= '0;
      r_rx    <= '0;
      r_tx    <= '0;
      r_miso  <= 1'b0;
      r_rwn   <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_bad   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_cmd <= '0;
          r_rx  <= '0;
          r_bad <= 1'b0;
        end
        S_CMD: begin
          if (w_rise) begin
            r_cmd <= w_cmd_nxt[6:0];
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_cmd_last) begin
              r_cnt <= '0;
              r_bad <= w_rsvd_bad;
              // Keep outputs from the last good access when the frame is rejected
              if (!w_rsvd_bad) begin
                r_addr <= w_cmd_nxt[ADDR_W-1:0];
                r_rwn  <= w_cmd_nxt[7];
              end
            end
          end
        end
        S_RD_CAP: r_tx <= reg_rdata;
        S_DATA: begin
          if (w_rise) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_rx  <= w_rx_nxt[DATA_W-2:0];
            if (w_data_last && !r_rwn) r_wdata <= w_rx_nxt;
          end
          if (w_fall && r_rwn) r_tx <= {r_tx[DATA_W-2:0], 1'b0};
        end
        default: ;
      endcase
      // MISO only carries read bits while in DATA; every exit forces it low
      if (w_state_nxt != S_DATA)
        r_miso <= 1'b0;
      else if (r_state == S_DATA && w_fall && r_rwn)
        r_miso <= r_tx[DATA_W-1];
    end
  end

  assign spi_miso  = r_miso;
  assign reg_addr  = r_addr;
  assign reg_r_wn  = r_rwn;
  assign reg_wdata = r_wdata;
  assign reg_req   = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
  assign busy      = (r_state != S_IDLE);
  assign frame_err = r_err;

endmodule

// File: tb/tb_spi_reg_bridge.sv
module tb_spi_reg_bridge;
  localparam int HP = 6; // SCLK half period in clk cycles

  logic        clk = 1'b0, reset;
  logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic [4:0]  reg_addr;
  logic        reg_r_wn, reg_req, busy, frame_err;
  logic [31:0] reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  spi_reg_bridge #(.ADDR_W(5), .DATA_W(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .reg_addr(reg_addr),
    .reg_r_wn(reg_r_wn), .reg_wdata(reg_wdata), .reg_req(reg_req),
    .reg_rdata(reg_rdata), .busy(busy), .frame_err(frame_err)
  );

  typedef struct packed { logic rwn; logic [4:0] addr; logic [31:0] wdata; } req_t;
  req_t exp_q[$];
  req_t obs_q[$];
  int   tests = 0, fails = 0, err_cnt = 0;

  // Register file model: initial contents are i*0x00010203, and read data is
  // returned 1 clk after the strobe.
  logic [31:0] mem [0:31];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= i * 32'h0001_0203;
      reg_rdata <= '0;
    end else if (reg_req) begin
      if (!reg_r_wn) mem[reg_addr] <= reg_wdata;
      reg_rdata <= mem[reg_addr];
    end
  end

  always @(negedge clk) begin
    if (reg_req) obs_q.push_back({reg_r_wn, reg_addr, reg_r_wn ? 32'h0 : reg_wdata});
    if (frame_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reqs(input string tag);
    chk({tag, "_req_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, "_req"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic cs_high(input int n);
    spi_cs_n = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (HP) @(negedge clk);
    m = spi_miso;
    spi_sclk = 1'b1;
    repeat (HP) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  // Shifts nbits bits of {cmd, data} MSB first, capturing MISO ahead of each rise
  task automatic send_bits(input logic [39:0] bits, input int nbits,
                           output logic [7:0] mcmd, output logic [31:0] mdat);
    logic m;
    mcmd = '0;
    mdat = '0;
    for (int i = 0; i < nbits; i++) begin
      xfer_bit(bits[39 - i], m);
      if (i < 8) mcmd = {mcmd[6:0], m};
      else       mdat = {mdat[30:0], m};
    end
  endtask

  logic [7:0]  mc;
  logic [31:0] md;
  int          e0;

  initial begin
    spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req",  64'(reg_req),   64'(0));
    chk("rst_rwn",  64'(reg_r_wn),  64'(1));
    chk("rst_addr", 64'(reg_addr),  64'(0));
    chk("rst_wdat", 64'(reg_wdata), 64'(0));
    chk("rst_miso", 64'(spi_miso),  64'(0));
    chk("rst_busy", 64'(busy),      64'(0));
    chk("rst_err",  64'(frame_err), 64'(0));

    // 1: write DEADBEEF to addr 5
    e0 = err_cnt;
    exp_q.push_back({1'b0, 5'd5, 32'hDEAD_BEEF});
    cs_low();
    chk("t1_busy", 64'(busy), 64'(1));
    send_bits({8'h05, 32'hDEAD_BEEF}, 40, mc, md);
    cs_high(10);
    check_reqs("t1");
    chk("t1_err",  64'(err_cnt - e0), 64'(0));
    chk("t1_busy_end", 64'(busy), 64'(0));

    // 2: read addr 1, model holds 0x00010203
    e0 = err_cnt;
    exp_q.push_back({1'b1, 5'd1, 32'h0});
    cs_low();
    send_bits({8'h81, 32'h0}, 40, mc, md);
    chk("t2_miso_cmd", 64'(mc), 64'(0));
    chk("t2_miso_dat", 64'(md), 64'h0001_0203);
    cs_high(10);
    check_reqs("t2");
    chk("t2_err", 64'(err_cnt - e0), 64'(0));

    // 3: write aborted after 12 data bits
    e0 = err_cnt;
    cs_low();
    send_bits({8'h03, 32'hFFF0_0000}, 20, mc, md);
    cs_high(10);
    check_reqs("t3");
    chk("t3_err",  64'(err_cnt - e0), 64'(1));
    chk("t3_busy", 64'(busy), 64'(0));

    // 4: reserved bits set; error only when CS_n rises
    e0 = err_cnt;
    cs_low();
    send_bits({8'hE5, 32'h1234_5678}, 40, mc, md);
    chk("t4_miso", 64'(md), 64'(0));
    chk("t4_err_pre", 64'(err_cnt - e0), 64'(0));
    chk("t4_busy_pre", 64'(busy), 64'(1));
    cs_high(10);
    chk("t4_err", 64'(err_cnt - e0), 64'(1));
    check_reqs("t4");

    // 5: reset after 20 bits with CS_n held low
    e0 = err_cnt;
    cs_low();
    send_bits({8'h07, 32'hABCD_EF01}, 20, mc, md);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", 64'(busy),      64'(0));
    chk("t5_rwn",  64'(reg_r_wn),  64'(1));
    chk("t5_addr", 64'(reg_addr),  64'(0));
    chk("t5_wdat", 64'(reg_wdata), 64'(0));
    chk("t5_miso", 64'(spi_miso),  64'(0));
    send_bits({8'h02, 32'h5555_5555}, 40, mc, md);
    chk("t5_busy_low", 64'(busy), 64'(0));
    cs_high(10);
    check_reqs("t5_ignored");
    exp_q.push_back({1'b0, 5'd4, 32'h0000_1234});
    cs_low();
    send_bits({8'h04, 32'h0000_1234}, 40, mc, md);
    cs_high(10);
    check_reqs("t5_next");
    chk("t5_err", 64'(err_cnt - e0), 64'(0));

    // 6: back-to-back write then read, CS_n high only 4 clk
    e0 = err_cnt;
    exp_q.push_back({1'b0, 5'd5, 32'hCAFE_F00D});
    exp_q.push_back({1'b1, 5'd5, 32'h0});
    cs_low();
    send_bits({8'h05, 32'hCAFE_F00D}, 40, mc, md);
    cs_high(4);
    cs_low();
    send_bits({8'h85, 32'h0}, 40, mc, md);
    chk("t6_miso", 64'(md), 64'hCAFE_F00D);
    cs_high(10);
    check_reqs("t6");
    chk("t6_err", 64'(err_cnt - e0), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
